// File: rtl/mandel_pixel_sink.sv
// Frame buffer sink for Mandelbrot pipeline results: saturates iteration counts to 8-bit colour,
// tracks per-pixel coverage for frame completion, and provides a 1-cycle pixel readback port.
module mandel_pixel_sink #(
  parameter int RESX = 32,
  parameter int RESY = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] xin,
  input  logic [10:0] yin,
  input  logic [31:0] v,
  input  logic        clear,
  input  logic        rd_en,
  input  logic [10:0] rd_x,
  input  logic [10:0] rd_y,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic [22:0] pix_count,
  output logic        frame_done,
  output logic        oob_err
);

  // state   | meaning
  // S_CLEAR | sweeping written bits to zero, input stalled
  // S_FILL  | accepting results, counting newly covered pixels
  // S_DONE  | every pixel covered; rewrites still update colour
  typedef enum logic [1:0] {S_CLEAR, S_FILL, S_DONE} state_t;

  localparam int NPIX = RESX * RESY;
  localparam int AW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [11:0] RESX_W = 12'(RESX);
  localparam logic [11:0] RESY_W = 12'(RESY);
  localparam logic [22:0] NPIX_W = 23'(NPIX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  state_t state, state_nxt;

  logic [7:0]      mem [NPIX];
  logic [NPIX-1:0] wbit;
  logic [AW-1:0]   sweep;
  logic [AW-1:0]   waddr, raddr;
  logic            w_in_range, r_in_range;
  logic            xfer, new_pix, sweep_last, last_pix;
  logic [7:0]      colour;

  assign in_ready   = (state != S_CLEAR);
  assign xfer       = in_valid && in_ready && !clear;
  assign w_in_range = ({1'b0, xin} < RESX_W) && ({1'b0, yin} < RESY_W);
  assign r_in_range = ({1'b0, rd_x} < RESX_W) && ({1'b0, rd_y} < RESY_W);
  // Modular arithmetic in AW bits is exact whenever the coordinates are in range.
  assign waddr      = AW'(yin) * AW'(RESX) + AW'(xin);
  assign raddr      = AW'(rd_y) * AW'(RESX) + AW'(rd_x);
  assign colour     = (|v[31:8]) ? 8'hFF : v[7:0];
  assign sweep_last = (sweep == LAST_ADDR);
  assign new_pix    = xfer && w_in_range && !wbit[waddr] && (state == S_FILL);
  assign last_pix   = new_pix && (pix_count == NPIX_W - 23'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_CLEAR;
    end else begin
      case (state)
        S_CLEAR: if (sweep_last) state_nxt = S_FILL;
        S_FILL:  if (last_pix)   state_nxt = S_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep      <= '0;
      wbit       <= '0;
      pix_count  <= '0;
      frame_done <= 1'b0;
      oob_err    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'd0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= (r_in_range && wbit[raddr]) ? mem[raddr] : 8'd0;
      if (clear) begin
        sweep      <= '0;
        pix_count  <= '0;
        frame_done <= 1'b0;
        oob_err    <= 1'b0;
      end else begin
        if (state == S_CLEAR) begin
          wbit[sweep] <= 1'b0;
          if (!sweep_last) sweep <= sweep + 1'b1;
        end
        if (xfer) begin
          if (w_in_range) wbit[waddr] <= 1'b1;
          else            oob_err     <= 1'b1;
        end
        if (new_pix)  pix_count  <= pix_count + 23'd1;
        if (last_pix) frame_done <= 1'b1;
      end
    end
  end

  // Colour storage needs no reset; the written bits qualify every read.
  always_ff @(posedge clk) begin
    if (xfer && w_in_range) mem[waddr] <= colour;
  end

endmodule

// File: tb/tb_mandel_pixel_sink.sv
// Directed self-checking bench for mandel_pixel_sink at the default 32x32 frame.
module tb_mandel_pixel_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] xin, yin;
  logic [31:0] v;
  logic        clear;
  logic        rd_en;
  logic [10:0] rd_x, rd_y;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [22:0] pix_count;
  logic        frame_done;
  logic        oob_err;

  int ncmp = 0;
  int nerr = 0;
  int cnt;

  mandel_pixel_sink #(.RESX(32), .RESY(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .xin(xin), .yin(yin), .v(v), .clear(clear),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid), .rd_data(rd_data),
    .pix_count(pix_count), .frame_done(frame_done), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int x, input int y, input int val);
    in_valid = 1'b1;
    xin = 11'(x);
    yin = 11'(y);
    v = 32'(val);
    step;
    in_valid = 1'b0;
  endtask

  task automatic rd(input int x, input int y, input int exp, input string tag);
    rd_en = 1'b1;
    rd_x = 11'(x);
    rd_y = 11'(y);
    step;
    rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles, input int start);
    cnt = start;
    while (!in_ready && cnt < 3000) begin
      step;
      cnt++;
    end
    check(tag, 32'(cnt), 32'(exp_cycles));
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    step;
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_count"}, 32'(pix_count), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_oob"}, 32'(oob_err), 32'd0);
    check({tag, "_rdv"}, 32'(rd_valid), 32'd0);
    check({tag, "_rdd"}, 32'(rd_data), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; xin = '0; yin = '0; v = '0;
    clear = 1'b0; rd_en = 1'b0; rd_x = '0; rd_y = '0;
    #3;
    check_all_zero("reset");
    repeat (3) step;
    rst_n = 1'b1;
    wait_ready("ready_after_reset", 1024, 0);

    // Diagonal stream: 32 distinct pixels, last value at (5,5) is 997 -> saturates to 255.
    for (int i = 0; i < 1024; i++) wr(i % 32, i % 32, i);
    check("diag_count", 32'(pix_count), 32'd32);
    check("diag_done", 32'(frame_done), 32'd0);
    check("diag_oob", 32'(oob_err), 32'd0);
    rd(5, 5, 255, "diag_rd55");
    rd(5, 6, 0, "diag_rd56");

    // Full raster fill with v=i, (0,1) overridden with 1000.
    pulse_clear;
    check("clr1_count", 32'(pix_count), 32'd0);
    wait_ready("clr1_sweep", 1024, 0);
    for (int i = 0; i < 1023; i++) wr(i % 32, i / 32, (i == 32) ? 1000 : i);
    check("fill_count_1023", 32'(pix_count), 32'd1023);
    check("fill_done_early", 32'(frame_done), 32'd0);
    wr(31, 31, 1023);
    check("fill_done", 32'(frame_done), 32'd1);
    check("fill_count", 32'(pix_count), 32'd1024);
    rd(0, 1, 255, "fill_rd01");
    rd(3, 0, 3, "fill_rd30");
    rd(0, 2, 64, "fill_rd02");
    wr(3, 0, 77);
    check("done_count_hold", 32'(pix_count), 32'd1024);
    check("done_done_hold", 32'(frame_done), 32'd1);
    check("done_ready", 32'(in_ready), 32'd1);
    rd(3, 0, 77, "done_rewrite");

    // Clear with a simultaneous transfer: clear wins.
    clear = 1'b1; in_valid = 1'b1; xin = 11'd4; yin = 11'd0; v = 32'd99;
    step;
    clear = 1'b0; in_valid = 1'b0;
    check("clr2_count", 32'(pix_count), 32'd0);
    check("clr2_done", 32'(frame_done), 32'd0);
    check("clr2_ready", 32'(in_ready), 32'd0);
    cnt = 0;
    repeat (8) begin step; cnt++; end
    rd_en = 1'b1; rd_x = 11'd3; rd_y = 11'd0;
    step; cnt++;
    rd_en = 1'b0;
    check("sweep_rd30", 32'(rd_data), 32'd0);
    wait_ready("clr2_sweep", 1024, cnt);
    rd(4, 0, 0, "clr2_not_accepted");

    // Out-of-range writes and rewrite counting.
    wr(40, 2, 5);
    check("oob_set", 32'(oob_err), 32'd1);
    check("oob_count", 32'(pix_count), 32'd0);
    wr(2, 2, 6);
    wr(2, 2, 7);
    check("rewrite_count", 32'(pix_count), 32'd1);
    check("oob_sticky", 32'(oob_err), 32'd1);
    wr(0, 32, 1);
    check("oob_y_count", 32'(pix_count), 32'd1);
    rd(2, 2, 7, "rewrite_rd22");

    // Read-before-write on the same address.
    wr(7, 7, 9);
    in_valid = 1'b1; xin = 11'd7; yin = 11'd7; v = 32'd20;
    rd_en = 1'b1; rd_x = 11'd7; rd_y = 11'd7;
    step;
    in_valid = 1'b0; rd_en = 1'b0;
    check("rbw_old", 32'(rd_data), 32'd9);
    check("rbw_count", 32'(pix_count), 32'd2);
    rd(7, 7, 20, "rbw_new");
    rd(33, 0, 0, "oob_read");
    step;
    check("rdv_drop", 32'(rd_valid), 32'd0);

    // Asynchronous reset while outputs are non-zero.
    rd_en = 1'b1; rd_x = 11'd7; rd_y = 11'd7;
    step;
    check("pre_rst_rdd", 32'(rd_data), 32'd20);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_fill");
    rd_en = 1'b0;
    rst_n = 1'b1;
    wait_ready("rst_fill_sweep", 1024, 0);

    // Clear mid-sweep restarts the sweep.
    wr(1, 1, 1);
    pulse_clear;
    repeat (100) step;
    pulse_clear;
    check("restart_oob", 32'(oob_err), 32'd0);
    wait_ready("restart_sweep", 1024, 0);

    // Reset mid-sweep.
    wr(1, 1, 1);
    rd_en = 1'b1; rd_x = 11'd1; rd_y = 11'd1;
    step;
    check("pre_rst2_rdd", 32'(rd_data), 32'd1);
    pulse_clear;
    repeat (50) step;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_sweep");
    rd_en = 1'b0;
    rst_n = 1'b1;
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mandel_pixel_sink.md
MANDEL_PIXEL_SINK -- requirements
Module: mandel_pixel_sink

Interface
REQ-001 The block SHALL have parameter RESX, default 32, frame width in pixels (1..2048).
REQ-002 The block SHALL have parameter RESY, default 32, frame height in pixels (1..2048).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, pipeline result present this cycle.
REQ-007 The block SHALL have port in_ready, output, 1, sink accepts a result this cycle.
REQ-008 The block SHALL have ports xin and yin, input, 11 each, result pixel coordinates.
REQ-009 The block SHALL have port v, input, 32, iteration count for the pixel.
REQ-010 The block SHALL have port clear, input, 1, single-cycle request to start a new frame.
REQ-011 The block SHALL have ports rd_en (input, 1), rd_x and rd_y (input, 11 each), rd_valid (output, 1) and rd_data (output, 8), forming the pixel readback port.
REQ-012 The block SHALL have ports pix_count (output, 23), frame_done (output, 1) and oob_err (output, 1).

Function
REQ-013 The block SHALL implement states CLEAR, FILL and DONE.
REQ-014 A transfer SHALL occur only when in_valid and in_ready are both 1; in_valid while in_ready is 0 SHALL be ignored, not queued.
REQ-015 in_ready SHALL be 1 in FILL and DONE and 0 in CLEAR.
REQ-016 For each transfer, stored colour SHALL be 255 if v > 255, else v[7:0], written at address yin*RESX+xin.
REQ-017 An internal per-pixel written bit SHALL be set on each in-range transfer.
REQ-018 pix_count SHALL increment by 1 only when the pixel's written bit was previously 0; a rewrite SHALL update the data without changing the count.
REQ-019 A transfer with xin >= RESX or yin >= RESY SHALL store nothing and SHALL set oob_err, which is sticky until reset or clear.
REQ-020 When a transfer raises pix_count to RESX*RESY, the block SHALL move to DONE and assert frame_done on the following cycle.
REQ-021 In DONE, further transfers SHALL still update data, and pix_count and frame_done SHALL hold.
REQ-022 CLEAR SHALL sweep one address per cycle from 0 to RESX*RESY-1, zeroing written bits, and then enter FILL; the sweep takes exactly RESX*RESY cycles.
REQ-023 On entry to CLEAR, pix_count, frame_done and oob_err SHALL go to 0 on the cycle after clear is sampled.
REQ-024 clear sampled in any state, including mid-sweep, SHALL restart the sweep at address 0.
REQ-025 clear and in_valid in the same cycle: clear SHALL win and the transfer SHALL NOT be accepted.
REQ-026 Readback SHALL have 1-cycle latency: rd_valid = registered rd_en, and rd_data = stored colour if the written bit is set, else 0.
REQ-027 An out-of-range read SHALL return rd_valid=1 with rd_data=0.
REQ-028 A read and a write to the same address in the same cycle SHALL return the old value (read-before-write).
REQ-029 Readback SHALL operate in every state; during CLEAR, already-swept addresses SHALL read 0.

Reset
REQ-030 Asserting rst_n low SHALL immediately force state=CLEAR, sweep address=0, in_ready=0, pix_count=0, frame_done=0, oob_err=0, rd_valid=0 and rd_data=0.
REQ-031 After rst_n rises, the block SHALL complete a full sweep (RESX*RESY cycles) before in_ready first becomes 1.
REQ-032 Frame data memory contents SHALL NOT need to be reset; the written bits alone define validity.

Verification
REQ-033 Reset, then count cycles -> in_ready rises exactly 1024 cycles after rst_n release (32x32).
REQ-034 Stream the diagonal pattern (x,y)=(i%32,i%32) for 1024 transfers -> pix_count=32, frame_done=0; reading (5,5) returns the v stored there, and reading (5,6) returns 0.
REQ-035 Write all 1024 pixels with v=i, including v=1000 at (0,1) -> frame_done=1 one cycle after the last write; reading (0,1) returns 255, and reading (3,0) returns 3.
REQ-036 Write (40,2), then write (2,2) twice -> oob_err=1 and pix_count=1.
REQ-037 After frame_done, pulse clear with in_valid=1 -> the transfer is not accepted, pix_count=0 and frame_done=0 the next cycle, and in_ready=0 for 1024 cycles.
REQ-038 Issue a same-cycle read and write to (7,7) with old value 9 and new v=20 -> rd_data=9, and the next read returns 20; assert rst_n low mid-sweep -> all outputs are 0 immediately.
